// File: rtl/int_fp_add_arbiter.sv
// Round-robin arbiter that shares one int_fp_add unit among N requesters.
// Holds one op in flight: grant, hold the operands for ADD_LAT+1 cycles, then return the result.
module int_fp_add_arbiter #(
  parameter int N       = 4,
  parameter int ADD_LAT = 0,
  parameter int IDW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N-1:0]    req_mode,
  input  logic [16*N-1:0] req_a,
  input  logic [16*N-1:0] req_b,
  output logic [N-1:0]    resp_valid,
  input  logic [N-1:0]    resp_ready,
  output logic [15:0]     resp_c,
  output logic            add_mode,
  output logic [15:0]     add_a,
  output logic [15:0]     add_b,
  input  logic [15:0]     add_c,
  output logic            busy,
  output logic [IDW-1:0]  grant_id
);

  localparam int CW = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id;
  logic [CW-1:0]  cnt;
  logic           mode_q;
  logic [15:0]    a_q;
  logic [15:0]    b_q;
  logic [15:0]    result;
  logic [IDW-1:0] winner;
  logic           found;

  // Search starts at rr_ptr and wraps, so the last winner has the lowest priority.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % N]) begin
        found  = 1'b1;
        winner = IDW'((int'(rr_ptr) + k) % N);
      end
    end
  end

  // Gated by rst_n so the handshake reads 0 immediately while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && found) req_ready[winner] = 1'b1;
  end

  always_comb begin
    resp_valid = '0;
    if (state == RESP) resp_valid[id] = 1'b1;
  end

  assign resp_c   = (state == RESP) ? result : 16'h0000;
  assign busy     = (state != IDLE);
  assign grant_id = id;
  assign add_mode = mode_q;
  assign add_a    = a_q;
  assign add_b    = b_q;

  // NOTE: operand and result registers are reset too, because add_* and grant_id must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      id     <= '0;
      cnt    <= '0;
      mode_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (found) begin
            id     <= winner;
            mode_q <= req_mode[winner];
            a_q    <= req_a[16*int'(winner) +: 16];
            b_q    <= req_b[16*int'(winner) +: 16];
            cnt    <= CW'(ADD_LAT);
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            result <= add_c;
            state  <= RESP;
          end
        end
        RESP: begin
          if (resp_ready[id]) begin
            rr_ptr <= (int'(id) == N - 1) ? '0 : id + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_fp_add_arbiter.sv
// Directed bench for int_fp_add_arbiter: one instance with a combinational adder,
// one with a two-stage pipelined adder model.
module tb_int_fp_add_arbiter;

  logic clk;
  logic rst_n;

  logic [3:0]  req_valid, req_ready, req_mode, resp_valid, resp_ready;
  logic [63:0] req_a, req_b;
  logic [15:0] resp_c, add_a, add_b, add_c;
  logic        add_mode, busy;
  logic [1:0]  grant_id;

  logic [3:0]  l2_req_valid, l2_req_ready, l2_req_mode, l2_resp_valid, l2_resp_ready;
  logic [63:0] l2_req_a, l2_req_b;
  logic [15:0] l2_resp_c, l2_add_a, l2_add_b, l2_add_c;
  logic        l2_add_mode, l2_busy;
  logic [1:0]  l2_grant_id;
  logic [15:0] l2_p1, l2_p2;

  int checks = 0;
  int errors = 0;
  int cyc, last, g;

  int_fp_add_arbiter #(.N(4), .ADD_LAT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_c(resp_c),
    .add_mode(add_mode), .add_a(add_a), .add_b(add_b), .add_c(add_c),
    .busy(busy), .grant_id(grant_id)
  );

  int_fp_add_arbiter #(.N(4), .ADD_LAT(2)) dut_l2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(l2_req_valid), .req_ready(l2_req_ready), .req_mode(l2_req_mode),
    .req_a(l2_req_a), .req_b(l2_req_b),
    .resp_valid(l2_resp_valid), .resp_ready(l2_resp_ready), .resp_c(l2_resp_c),
    .add_mode(l2_add_mode), .add_a(l2_add_a), .add_b(l2_add_b), .add_c(l2_add_c),
    .busy(l2_busy), .grant_id(l2_grant_id)
  );

  // Stand-in adder: INT adds 16-bit; the FP16 path only models x+x (exponent + 1).
  function automatic logic [15:0] model_add(input logic m, input logic [15:0] a, input logic [15:0] b);
    return m ? a + 16'h0400 : a + b;
  endfunction

  assign add_c = model_add(add_mode, add_a, add_b);

  always @(posedge clk) begin
    l2_p1 <= model_add(l2_add_mode, l2_add_a, l2_add_b);
    l2_p2 <= l2_p1;
  end
  assign l2_add_c = l2_p2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic m, input logic [15:0] a, input logic [15:0] b);
    req_mode[i]       = m;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 4'hF; req_mode = '0; req_a = '0; req_b = '0; resp_ready = 4'hF;
    l2_req_valid = '0; l2_req_mode = '0; l2_req_a = '0; l2_req_b = '0; l2_resp_ready = 4'hF;

    // Reset state, with every requester valid.
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", req_ready, 4'h0);
    check("rst_resp_valid", resp_valid, 4'h0);
    check("rst_resp_c", resp_c, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_grant_id", grant_id, 2'd0);
    check("rst_add_a", add_a, 16'h0000);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // T1: INT op from req0.
    @(negedge clk);
    req_valid = 4'b0001; set_op(0, 1'b0, 16'h0102, 16'h0304);
    #1 check("t1_ready", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("t1_busy", busy, 1'b1);
    check("t1_add_a", add_a, 16'h0102);
    check("t1_add_b", add_b, 16'h0304);
    check("t1_exec_resp", resp_valid, 4'h0);
    @(negedge clk);
    #1;
    check("t1_resp_valid", resp_valid, 4'b0001);
    check("t1_resp_c", resp_c, 16'h0406);
    @(negedge clk);
    #1;
    check("t1_idle_resp", resp_valid, 4'h0);
    check("t1_idle_busy", busy, 1'b0);

    // T2: FP16 op from req2 (rr_ptr is 1 now).
    @(negedge clk);
    req_valid = 4'b0100; set_op(2, 1'b1, 16'h3C00, 16'h3C00);
    #1 check("t2_ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("t2_add_mode", add_mode, 1'b1);
    check("t2_grant_id", grant_id, 2'd2);
    @(negedge clk);
    #1;
    check("t2_resp_valid", resp_valid, 4'b0100);
    check("t2_resp_c", resp_c, 16'h4000);

    // T3: all requesters valid from a fresh reset; grants rotate every 3 cycles.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_op(i, 1'b0, 16'(i * 256), 16'h0001);
    rst_n = 1'b1;
    req_valid = 4'hF;
    cyc = 0; last = 0; g = 0;
    while (g < 6 && cyc < 40) begin
      #1;
      cyc++;
      if (req_ready != 4'h0) begin
        check("t3_grant", req_ready, 4'b0001 << (g % 4));
        if (g > 0) check("t3_interval", cyc - last, 3);
        last = cyc;
        g++;
      end
      @(negedge clk);
    end
    check("t3_grant_count", g, 6);
    req_valid = '0;
    repeat (2) @(negedge clk);

    // T4: req1 holds off its response for 5 RESP cycles; other resp_ready bits high.
    req_valid = 4'b0010; set_op(1, 1'b0, 16'h1111, 16'h2222); resp_ready = 4'b1101;
    #1 check("t4_ready", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = 4'hF; set_op(1, 1'b0, 16'hFFFF, 16'hFFFF);
    #1 check("t4_add_a_held", add_a, 16'h1111);
    @(negedge clk);
    #1;
    check("t4_resp_valid", resp_valid, 4'b0010);
    check("t4_resp_c", resp_c, 16'h3333);
    repeat (4) begin
      @(negedge clk);
      #1;
      check("t4_hold_valid", resp_valid, 4'b0010);
      check("t4_hold_c", resp_c, 16'h3333);
      check("t4_hold_ready", req_ready, 4'h0);
    end
    @(negedge clk);
    resp_ready = 4'hF;
    #1 check("t4_last_valid", resp_valid, 4'b0010);
    @(negedge clk);
    #1;
    check("t4_done_valid", resp_valid, 4'h0);
    check("t4_next_grant", req_ready, 4'b0100);

    // T6: reset during EXEC of req2 with every requester valid.
    @(negedge clk);
    #1;
    check("t6_exec_busy", busy, 1'b1);
    check("t6_exec_id", grant_id, 2'd2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_ready", req_ready, 4'h0);
    check("t6_rst_resp", resp_valid, 4'h0);
    check("t6_rst_id", grant_id, 2'd0);
    check("t6_rst_add_a", add_a, 16'h0000);
    @(negedge clk);
    set_op(0, 1'b0, 16'h0010, 16'h0001);
    rst_n = 1'b1;
    #1 check("t6_first_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    #1 check("t6_grant_id", grant_id, 2'd0);
    @(negedge clk);
    #1;
    check("t6_resp_valid", resp_valid, 4'b0001);
    check("t6_resp_c", resp_c, 16'h0011);

    // T5: ADD_LAT=2 instance, req3 op; EXEC lasts 3 cycles.
    @(negedge clk);
    l2_req_valid = 4'b1000; l2_req_mode[3] = 1'b0;
    l2_req_a[63:48] = 16'h1234; l2_req_b[63:48] = 16'h0101;
    #1 check("t5_ready", l2_req_ready, 4'b1000);
    @(negedge clk);
    l2_req_valid = '0; l2_req_a = '1; l2_req_b = '1;
    #1;
    check("t5_busy", l2_busy, 1'b1);
    check("t5_add_a", l2_add_a, 16'h1234);
    check("t5_add_b", l2_add_b, 16'h0101);
    repeat (2) begin
      @(negedge clk);
      #1;
      check("t5_hold_a", l2_add_a, 16'h1234);
      check("t5_hold_b", l2_add_b, 16'h0101);
      check("t5_no_resp", l2_resp_valid, 4'h0);
    end
    @(negedge clk);
    #1;
    check("t5_resp_valid", l2_resp_valid, 4'b1000);
    check("t5_resp_c", l2_resp_c, 16'h1335);
    @(negedge clk);
    #1;
    check("t5_idle_resp", l2_resp_valid, 4'h0);
    check("t5_idle_busy", l2_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
